// File: rtl/fpu_issue_ctrl_if.sv
// rtl/fpu_issue_ctrl_if.sv - request, response and FPU operand/result bundle for fpu_issue_ctrl
interface fpu_issue_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_funct;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [1:0]  fpu_funct;
    logic [31:0] fpu_a;
    logic [31:0] fpu_b;
    logic [31:0] fpu_o;
    logic        fpu_div_fin;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_o;
    logic        rsp_timeout;
    logic        busy;

    // slave: the issue controller itself
    modport slave (
        input  req_valid, req_funct, req_a, req_b, fpu_o, fpu_div_fin, rsp_ready,
        output req_ready, fpu_funct, fpu_a, fpu_b, rsp_valid, rsp_o, rsp_timeout, busy
    );

    // master: sequencer plus FPU surrounding the controller
    modport master (
        output req_valid, req_funct, req_a, req_b, fpu_o, fpu_div_fin, rsp_ready,
        input  req_ready, fpu_funct, fpu_a, fpu_b, rsp_valid, rsp_o, rsp_timeout, busy
    );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// rtl/fpu_issue_ctrl.sv - serialising issue controller for the shared FPU datapath
module fpu_issue_ctrl #(
    parameter int SETTLE      = 2,
    parameter int DIV_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    fpu_issue_ctrl_if.slave    bus
);
    localparam int CNT_MAX = (SETTLE > DIV_TIMEOUT) ? SETTLE : DIV_TIMEOUT;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE - 1);
    localparam logic [CW-1:0] DIV_LD    = CW'(DIV_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [1:0]    FUNCT_DIV = 2'd2;
    localparam logic [31:0]   QNAN      = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  fpu_funct_q, fpu_funct_d;
    logic [31:0] fpu_a_q, fpu_a_d;
    logic [31:0] fpu_b_q, fpu_b_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        armed_q, armed_d;
    logic [31:0] rsp_o_q, rsp_o_d;
    logic        rsp_timeout_q, rsp_timeout_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            fpu_funct_q   <= 2'd0;
            fpu_a_q       <= 32'd0;
            fpu_b_q       <= 32'd0;
            cnt_q         <= '0;
            armed_q       <= 1'b0;
            rsp_o_q       <= 32'd0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fpu_funct_q   <= fpu_funct_d;
            fpu_a_q       <= fpu_a_d;
            fpu_b_q       <= fpu_b_d;
            cnt_q         <= cnt_d;
            armed_q       <= armed_d;
            rsp_o_q       <= rsp_o_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        fpu_funct_d   = fpu_funct_q;
        fpu_a_d       = fpu_a_q;
        fpu_b_d       = fpu_b_q;
        cnt_d         = cnt_q;
        armed_d       = armed_q;
        rsp_o_d       = rsp_o_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    fpu_funct_d = bus.req_funct;
                    fpu_a_d     = bus.req_a;
                    fpu_b_d     = bus.req_b;
                    cnt_d       = (bus.req_funct == FUNCT_DIV) ? DIV_LD : SETTLE_LD;
                    armed_d     = 1'b0;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (fpu_funct_q != FUNCT_DIV) begin
                    if (cnt_q == '0) begin
                        rsp_o_d       = bus.fpu_o;
                        rsp_timeout_d = 1'b0;
                        state_d       = ST_RESP;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end else if (!armed_q) begin
                    // A finish flag still high from the previous divide is not trusted here
                    armed_d = 1'b1;
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end else if (bus.fpu_div_fin) begin
                    rsp_o_d       = bus.fpu_o;
                    rsp_timeout_d = 1'b0;
                    state_d       = ST_RESP;
                end else if (cnt_q == '0) begin
                    rsp_o_d       = QNAN;
                    rsp_timeout_d = 1'b1;
                    state_d       = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.req_ready   = (state_q == ST_IDLE) & ~rst;
    assign bus.rsp_valid   = (state_q == ST_RESP);
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.fpu_funct   = fpu_funct_q;
    assign bus.fpu_a       = fpu_a_q;
    assign bus.fpu_b       = fpu_b_q;
    assign bus.rsp_o       = rsp_o_q;
    assign bus.rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb/tb_fpu_issue_ctrl.sv - directed self-checking bench for fpu_issue_ctrl
module tb_fpu_issue_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [1:0]  req_funct = 2'd0;
    logic [31:0] req_a = 32'd0;
    logic [31:0] req_b = 32'd0;
    logic        rsp_ready = 1'b0;
    logic [31:0] fpu_o_drv = 32'd0;
    logic        fin_drv = 1'b0;
    logic        stub_mode = 1'b0;
    logic [31:0] fpu_o_mux;
    logic        fin_mux;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fpu_issue_ctrl_if bus8();
    fpu_issue_ctrl_if bus64();

    // FPU stub: either directly driven, or a bitwise function of the presented operands
    assign fpu_o_mux = stub_mode ? (bus8.fpu_a ^ bus8.fpu_b) : fpu_o_drv;
    assign fin_mux   = stub_mode ? 1'b1 : fin_drv;

    assign bus8.req_valid    = req_valid;
    assign bus8.req_funct    = req_funct;
    assign bus8.req_a        = req_a;
    assign bus8.req_b        = req_b;
    assign bus8.rsp_ready    = rsp_ready;
    assign bus8.fpu_o        = fpu_o_mux;
    assign bus8.fpu_div_fin  = fin_mux;
    assign bus64.req_valid   = req_valid;
    assign bus64.req_funct   = req_funct;
    assign bus64.req_a       = req_a;
    assign bus64.req_b       = req_b;
    assign bus64.rsp_ready   = rsp_ready;
    assign bus64.fpu_o       = fpu_o_mux;
    assign bus64.fpu_div_fin = fin_mux;

    fpu_issue_ctrl #(.SETTLE(2), .DIV_TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    fpu_issue_ctrl #(.SETTLE(2), .DIV_TIMEOUT(64)) dut64 (
        .clk (clk),
        .rst (rst),
        .bus (bus64)
    );

    task automatic issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        req_funct = f;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        checks++;
        if (bus8.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready: got %b want 1", bus8.req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus8.req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b want 0", bus8.req_ready); end
        checks++; if (bus8.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", bus8.rsp_valid); end
        checks++; if (bus8.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus8.busy); end
        checks++; if (bus8.rsp_o !== 32'd0) begin errors++; $display("FAIL rst_rsp_o: got %h want 0", bus8.rsp_o); end
        checks++; if (bus8.rsp_timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b want 0", bus8.rsp_timeout); end
        checks++; if ({bus8.fpu_funct, bus8.fpu_a, bus8.fpu_b} !== 66'd0) begin errors++; $display("FAIL rst_fpu_bus: got %h %h %h want 0", bus8.fpu_funct, bus8.fpu_a, bus8.fpu_b); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus8.req_ready !== 1'b1) begin errors++; $display("FAIL idle_req_ready: got %b want 1", bus8.req_ready); end
    endtask

    task automatic test_add;
        rsp_ready = 1'b0;
        fpu_o_drv = 32'h4040_0000;
        issue(2'd0, 32'h3F80_0000, 32'h4000_0000);
        @(negedge clk);
        checks++; if (bus8.fpu_a !== 32'h3F80_0000 || bus8.fpu_b !== 32'h4000_0000 || bus8.fpu_funct !== 2'd0) begin
            errors++; $display("FAIL add_operands: got %h %h %h want 0 3f800000 40000000", bus8.fpu_funct, bus8.fpu_a, bus8.fpu_b); end
        checks++; if (bus8.rsp_valid !== 1'b0 || bus8.busy !== 1'b1) begin errors++; $display("FAIL add_t0: got valid %b busy %b want 0 1", bus8.rsp_valid, bus8.busy); end
        @(negedge clk);
        checks++; if (bus8.rsp_valid !== 1'b0) begin errors++; $display("FAIL add_t1_valid: got %b want 0", bus8.rsp_valid); end
        @(negedge clk);
        checks++; if (bus8.rsp_valid !== 1'b1) begin errors++; $display("FAIL add_t2_valid: got %b want 1", bus8.rsp_valid); end
        checks++; if (bus8.rsp_o !== 32'h4040_0000 || bus8.rsp_timeout !== 1'b0) begin
            errors++; $display("FAIL add_result: got %h to %b want 40400000 to 0", bus8.rsp_o, bus8.rsp_timeout); end
        rsp_ready = 1'b1;
        fpu_o_drv = 32'h0BAD_0BAD;
        @(negedge clk);
        checks++; if (bus8.rsp_valid !== 1'b0 || bus8.req_ready !== 1'b1) begin errors++; $display("FAIL add_done: got valid %b ready %b want 0 1", bus8.rsp_valid, bus8.req_ready); end
        checks++; if (bus8.fpu_a !== 32'h3F80_0000 || bus8.fpu_b !== 32'h4000_0000) begin errors++; $display("FAIL add_hold: got %h %h want 3f800000 40000000", bus8.fpu_a, bus8.fpu_b); end
        checks++; if (bus8.rsp_o !== 32'h4040_0000) begin errors++; $display("FAIL add_rsp_hold: got %h want 40400000", bus8.rsp_o); end
    endtask

    task automatic test_mul_backpressure;
        rsp_ready = 1'b0;
        fpu_o_drv = 32'h40C0_0000;
        issue(2'd3, 32'h4000_0000, 32'h4040_0000);
        repeat (3) @(negedge clk);
        fpu_o_drv = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus8.rsp_valid !== 1'b1 || bus8.rsp_o !== 32'h40C0_0000) begin
                errors++; $display("FAIL mul_bp_hold[%0d]: got valid %b o %h want 1 40c00000", i, bus8.rsp_valid, bus8.rsp_o); end
            checks++; if (bus8.req_ready !== 1'b0 || bus8.busy !== 1'b1) begin
                errors++; $display("FAIL mul_bp_ready[%0d]: got ready %b busy %b want 0 1", i, bus8.req_ready, bus8.busy); end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus8.rsp_valid !== 1'b0 || bus8.req_ready !== 1'b1 || bus8.busy !== 1'b0) begin
            errors++; $display("FAIL mul_release: got valid %b ready %b busy %b want 0 1 0", bus8.rsp_valid, bus8.req_ready, bus8.busy); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_div_stale;
        rsp_ready = 1'b0;
        fin_drv   = 1'b1;
        fpu_o_drv = 32'h1111_1111;
        issue(2'd2, 32'h3F80_0000, 32'h4000_0000);
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus64.rsp_valid !== 1'b0) begin errors++; $display("FAIL div_stale_t1: got valid %b want 0", bus64.rsp_valid); end
        fin_drv = 1'b0;
        repeat (8) @(negedge clk);
        checks++; if (bus64.rsp_valid !== 1'b0) begin errors++; $display("FAIL div_stale_t9: got valid %b want 0", bus64.rsp_valid); end
        fin_drv   = 1'b1;
        fpu_o_drv = 32'h3F00_0000;
        @(negedge clk);
        checks++; if (bus64.rsp_valid !== 1'b1 || bus64.rsp_o !== 32'h3F00_0000 || bus64.rsp_timeout !== 1'b0) begin
            errors++; $display("FAIL div_fin_t10: got valid %b o %h to %b want 1 3f000000 0", bus64.rsp_valid, bus64.rsp_o, bus64.rsp_timeout); end
        rsp_ready = 1'b1;
        fin_drv   = 1'b0;
        @(negedge clk);
        checks++; if (bus64.busy !== 1'b0 || bus8.busy !== 1'b0) begin errors++; $display("FAIL div_stale_idle: got busy %b %b want 0 0", bus64.busy, bus8.busy); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_div_timeout;
        rsp_ready = 1'b0;
        fin_drv   = 1'b0;
        fpu_o_drv = 32'h1234_5678;
        issue(2'd2, 32'h3F80_0000, 32'h0000_0000);
        repeat (8) @(negedge clk);
        checks++; if (bus8.rsp_valid !== 1'b0) begin errors++; $display("FAIL div_to_t7: got valid %b want 0", bus8.rsp_valid); end
        @(negedge clk);
        checks++; if (bus8.rsp_valid !== 1'b1 || bus8.rsp_o !== 32'h7FC0_0000 || bus8.rsp_timeout !== 1'b1) begin
            errors++; $display("FAIL div_to_t8: got valid %b o %h to %b want 1 7fc00000 1", bus8.rsp_valid, bus8.rsp_o, bus8.rsp_timeout); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        issue(2'd2, 32'h4080_0000, 32'h4000_0000);
        repeat (8) @(negedge clk);
        checks++; if (bus8.rsp_valid !== 1'b0) begin errors++; $display("FAIL div_edge_t7: got valid %b want 0", bus8.rsp_valid); end
        fin_drv   = 1'b1;
        fpu_o_drv = 32'h3E80_0000;
        @(negedge clk);
        checks++; if (bus8.rsp_valid !== 1'b1 || bus8.rsp_o !== 32'h3E80_0000 || bus8.rsp_timeout !== 1'b0) begin
            errors++; $display("FAIL div_edge_t8: got valid %b o %h to %b want 1 3e800000 0", bus8.rsp_valid, bus8.rsp_o, bus8.rsp_timeout); end
        rsp_ready = 1'b1;
        fin_drv   = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_wait;
        rsp_ready = 1'b0;
        fin_drv   = 1'b0;
        issue(2'd2, 32'h4040_0000, 32'h3F80_0000);
        repeat (3) @(negedge clk);
        checks++; if (bus8.busy !== 1'b1) begin errors++; $display("FAIL rmw_busy: got %b want 1", bus8.busy); end
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++; if (bus8.busy !== 1'b0 || bus8.rsp_valid !== 1'b0 || bus8.req_ready !== 1'b0) begin
            errors++; $display("FAIL rmw_ctrl: got busy %b valid %b ready %b want 0 0 0", bus8.busy, bus8.rsp_valid, bus8.req_ready); end
        checks++; if (bus8.rsp_o !== 32'd0 || bus8.rsp_timeout !== 1'b0) begin
            errors++; $display("FAIL rmw_rsp: got %h %b want 0 0", bus8.rsp_o, bus8.rsp_timeout); end
        checks++; if ({bus8.fpu_funct, bus8.fpu_a, bus8.fpu_b} !== 66'd0) begin
            errors++; $display("FAIL rmw_fpu_bus: got %h %h %h want 0", bus8.fpu_funct, bus8.fpu_a, bus8.fpu_b); end
        @(negedge clk);
        rst = 1'b0;
        fpu_o_drv = 32'h40A0_0000;
        issue(2'd0, 32'h4000_0000, 32'h4040_0000);
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus8.rsp_valid !== 1'b0) begin errors++; $display("FAIL rmw_no_stale: got valid %b want 0", bus8.rsp_valid); end
        @(negedge clk);
        checks++; if (bus8.rsp_valid !== 1'b1 || bus8.rsp_o !== 32'h40A0_0000) begin
            errors++; $display("FAIL rmw_add: got valid %b o %h want 1 40a00000", bus8.rsp_valid, bus8.rsp_o); end
        rsp_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [1:0]  op_f [4];
        logic [31:0] op_a [4];
        logic [31:0] op_b [4];
        logic [31:0] exp_o [4];
        int idx_req;
        int idx_rsp;
        int last_acc;
        op_f[0] = 2'd0; op_a[0] = 32'h3F80_0000; op_b[0] = 32'h4000_0000; exp_o[0] = 32'h7F80_0000;
        op_f[1] = 2'd1; op_a[1] = 32'h4040_0000; op_b[1] = 32'h3F00_0000; exp_o[1] = 32'h7F40_0000;
        op_f[2] = 2'd3; op_a[2] = 32'h4000_0000; op_b[2] = 32'h4040_0000; exp_o[2] = 32'h0040_0000;
        op_f[3] = 2'd2; op_a[3] = 32'h4120_0000; op_b[3] = 32'h4000_0000; exp_o[3] = 32'h0120_0000;
        idx_req   = 0;
        idx_rsp   = 0;
        last_acc  = 0;
        stub_mode = 1'b1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus8.rsp_valid === 1'b1) begin
                checks++; if (bus8.rsp_o !== exp_o[idx_rsp] || bus8.rsp_timeout !== 1'b0) begin
                    errors++; $display("FAIL b2b_rsp[%0d]: got %h to %b want %h to 0", idx_rsp, bus8.rsp_o, bus8.rsp_timeout, exp_o[idx_rsp]); end
                idx_rsp++;
            end
            if (idx_req < 4) begin
                req_funct = op_f[idx_req];
                req_a     = op_a[idx_req];
                req_b     = op_b[idx_req];
                req_valid = 1'b1;
                if (bus8.req_ready === 1'b1) begin
                    if (idx_req > 0) begin
                        checks++; if (cyc - last_acc !== 4) begin
                            errors++; $display("FAIL b2b_spacing[%0d]: got %0d want 4", idx_req, cyc - last_acc); end
                    end
                    last_acc = cyc;
                    idx_req++;
                end
            end else begin
                req_valid = 1'b0;
            end
            if (idx_rsp == 4) break;
        end
        req_valid = 1'b0;
        checks++; if (idx_rsp !== 4) begin errors++; $display("FAIL b2b_count: got %0d responses want 4", idx_rsp); end
        stub_mode = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul_backpressure();
        test_div_stale();
        test_div_timeout();
        test_reset_mid_wait();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fpu_issue_ctrl.md
# fpu_issue_ctrl

Initiator-side controller that drives the shared `fpu` datapath. It accepts one operation request at a time over a valid/ready handshake and presents the operands and function select to the FPU. It waits the required settle time or the divider finish flag, then captures the result and returns it over a second valid/ready handshake. It sits between the instruction/microcode sequencer and the `fpu`, and serialises all FPU traffic.

## Interface

Parameters:
- `SETTLE`, default 2: number of WAIT cycles for add/sub/mul before `fpu_o` is sampled; minimum 1.
- `DIV_TIMEOUT`, default 64: maximum number of WAIT cycles for a divide; minimum 2.

Ports. One clock; reset is asynchronous and active-high.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: a request is present.
- `req_ready` out 1: controller accepts a request this cycle.
- `req_funct` in 2: 0 = add, 1 = sub, 2 = div, 3 = mul.
- `req_a`, `req_b` in 32: IEEE-754 single-precision operands.
- `fpu_funct` out 2: registered function select to the FPU.
- `fpu_a`, `fpu_b` out 32: registered operands to the FPU.
- `fpu_o` in 32: FPU result.
- `fpu_div_fin` in 1: divider finish flag.
- `rsp_valid` out 1: response is present.
- `rsp_ready` in 1: consumer takes the response.
- `rsp_o` out 32: captured result.
- `rsp_timeout` out 1: the divide timed out, and `rsp_o` holds the canonical qNaN.
- `busy` out 1: high whenever state is not IDLE.

## Operation

- FSM states: IDLE, WAIT, RESP.
- **IDLE:**
  - `req_ready` = 1.
  - On `req_valid & req_ready`: latch `req_funct`/`req_a`/`req_b` into `fpu_funct`/`fpu_a`/`fpu_b` and go to WAIT.
  - Load `cnt` with `SETTLE-1` for funct 0/1/3, or `DIV_TIMEOUT-1` for funct 2.
  - Clear `armed`.
- **WAIT, funct 0/1/3:**
  - If `cnt`==0: capture `fpu_o` into `rsp_o`, set `rsp_timeout`=0, go to RESP.
  - Otherwise decrement `cnt`.
  - `fpu_div_fin` is ignored.
- **WAIT, funct 2:**
  - First WAIT cycle: set `armed`=1 and do not test `fpu_div_fin`. This rejects a stale finish flag left by a previous divide.
  - Once `armed`, if `fpu_div_fin`==1: capture `fpu_o`, set `rsp_timeout`=0, go to RESP.
  - Else if `cnt`==0: set `rsp_o`=32'h7FC00000, set `rsp_timeout`=1, go to RESP.
  - Else decrement `cnt`.
  - If finish and the timeout condition occur in the same cycle, finish wins.
- **RESP:**
  - `rsp_valid` = 1; `rsp_o` and `rsp_timeout` are held stable.
  - On `rsp_ready`: go to IDLE.
  - `req_ready` = 0 throughout, so there is no overlap of request and response.
- `fpu_funct`/`fpu_a`/`fpu_b` hold their last values in every state until the next accept. The FPU output must not glitch between operations.
- `cnt` width is $clog2(max(`SETTLE`, `DIV_TIMEOUT`)) bits. It never wraps: it is only decremented while nonzero.
- No operand inspection and no arithmetic is performed here. NaN, zero and denormal handling belongs to the FPU.

## Timing

- Reset values:
  - `req_ready`=0 while `rst` is asserted, then 1 (state IDLE).
  - `rsp_valid`=0, `rsp_o`=0, `rsp_timeout`=0, `busy`=0.
  - `fpu_funct`=0, `fpu_a`=0, `fpu_b`=0.
  - `cnt`=0, `armed`=0.
- Asserting `rst` in any state, including mid-WAIT or RESP, returns the block to IDLE immediately. Any pending response is discarded.
- Add/sub/mul latency: accept at edge T means `fpu_*` are valid after T; `rsp_valid` rises after edge T+`SETTLE`.
- Divide latency:
  - `fpu_div_fin` is first sampled at edge T+2.
  - If it is first seen high at edge T+k, `rsp_valid` rises after T+k.
  - With no finish, the timeout response appears after edge T+`DIV_TIMEOUT`.
- Back-to-back throughput: a new request can be accepted no earlier than the edge after the response handshake (IDLE lasts at least one cycle). Minimum period is `SETTLE`+2 cycles.
- `rsp_valid` stays high indefinitely under `rsp_ready`=0; `busy` stays high.

## Test plan

- Reset, then add: `req_funct`=0, `a`=32'h3F800000, `b`=32'h40000000 with the FPU stub returning 32'h40400000 → `rsp_valid` 2 cycles after accept, `rsp_o`=32'h40400000, `rsp_timeout`=0; `fpu_a`/`fpu_b` are held after the response.
- Mul under backpressure: `a`=32'h40000000, `b`=32'h40400000, stub returns 32'h40C00000, `rsp_ready` held low for 5 cycles → `rsp_o` stable for all 5 cycles, `req_ready`=0 throughout; returns to IDLE one edge after `rsp_ready`=1.
- Divide with stale finish: `fpu_div_fin` already high at accept, then driven low, then high at T+10 with `fpu_o`=32'h3F000000 → the stale flag is ignored at T+1; `rsp_o`=32'h3F000000 after edge T+10.
- Divide timeout: `DIV_TIMEOUT`=8, `fpu_div_fin` held at 0 → `rsp_valid` after T+8, `rsp_o`=32'h7FC00000, `rsp_timeout`=1. Repeat with `fin`=1 exactly at T+8 → normal result, `rsp_timeout`=0.
- Reset mid-WAIT: assert `rst` at T+3 of a divide → all outputs at their reset values at once. After release, a new add completes normally with no stale response.
- Back-to-back stream of 4 mixed operations with `rsp_ready`=1 → each response matches its request in order; accept-to-accept spacing is exactly `SETTLE`+2 cycles for add/sub/mul.
